// File: rtl/trg_src_sched_pkg.sv
// Shared encodings for the trigger-source scheduler: FSM states,
// trigger-source codes reported on trg_src_out and source-mask bit positions.
`timescale 1ns/1ps
package trg_src_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_BUSY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_COIN = 2'd1,
    SRC_EXT  = 2'd2,
    SRC_CYC  = 2'd3
  } src_t;

  localparam int MSK_COIN = 0;
  localparam int MSK_EXT  = 1;
  localparam int MSK_CYC  = 2;

endpackage

// File: rtl/trg_src_sched_cyc_gen.sv
// Cycled-trigger generator: free-running counter 0..period-1 that emits a
// one-clock tick on the wrap cycle. Held at 0 while not running or when the
// period is 0.
`timescale 1ns/1ps
module trg_cyc_gen #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CYC_W-1:0] period,
  output logic             tick
);

  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] last;
  logic             active;

  assign active = run && (period != '0);
  assign last   = period - 1'b1;
  assign tick   = active && (cnt == last);

  // Period counter; a count above the new last value (period lowered) restarts at 0 without a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (cnt >= last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trg_src_sched.sv
// Trigger-source scheduler: arbitrates external, coincidence and cycled
// triggers (ext > coin > cyc), grants one source per downstream transaction,
// waits for the output controller to acknowledge and go idle, and keeps the
// trigger ID, per-source and lost-trigger counters.
`timescale 1ns/1ps
module trg_src_sched
  import trg_src_sched_pkg::*;
#(
  parameter int CYC_W   = 16,
  parameter int PRE_W   = 8,
  parameter int CNT_W   = 16,
  parameter int ACK_TMO = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             run_enb_in,
  input  logic [2:0]       src_mask_in,
  input  logic             coincid_trg_in,
  input  logic             ext_trg_syn_in,
  input  logic [CYC_W-1:0] cyc_period_in,
  input  logic [PRE_W-1:0] coincid_prescale_in,
  input  logic             eff_trg_in,
  input  logic             trg_busy_in,
  input  logic             cnt_clr_in,
  output logic             coincid_trg_out,
  output logic             ext_trg_out,
  output logic             cycled_trg_out,
  output logic             trg_enb_out,
  output logic [1:0]       trg_src_out,
  output logic [CNT_W-1:0] trg_id_out,
  output logic [CNT_W-1:0] coincid_cnt_out,
  output logic [CNT_W-1:0] ext_cnt_out,
  output logic [CNT_W-1:0] cyc_cnt_out,
  output logic [CNT_W-1:0] lost_trg_cnt_out
);

  localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
  localparam int LOST_W = CNT_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic             coin_d;
  logic [PRE_W-1:0] pre_cnt;
  logic             cyc_pend;
  logic             cyc_tick;
  logic [TMO_W-1:0] tmo_cnt;

  logic             in_idle;
  logic             coin_edge;
  logic             coin_m;
  logic             ext_m;
  logic             req_ok;
  logic             pre_hit;
  logic             ext_req;
  logic             coin_req;
  logic             cyc_req;
  logic             coin_win;
  logic             cyc_win;
  logic             grant;
  logic             tmo_exp;
  logic [2:0]       lost_inc;
  logic [LOST_W-1:0] lost_sum;

  trg_cyc_gen #(
    .CYC_W (CYC_W)
  ) u_cyc_gen (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .run    (run_enb_in & src_mask_in[MSK_CYC]),
    .period (cyc_period_in),
    .tick   (cyc_tick)
  );

  assign in_idle   = (state == ST_IDLE);
  assign coin_edge = coincid_trg_in & ~coin_d;
  assign coin_m    = coin_edge & src_mask_in[MSK_COIN];
  assign ext_m     = ext_trg_syn_in & src_mask_in[MSK_EXT];
  assign req_ok    = in_idle & run_enb_in;
  // A prescale lowered below the running count accepts the next edge instead of stalling
  assign pre_hit   = (pre_cnt >= coincid_prescale_in);

  assign ext_req   = req_ok & ext_m;
  assign coin_req  = req_ok & coin_m & pre_hit;
  assign cyc_req   = req_ok & cyc_pend;

  assign coin_win  = coin_req & ~ext_req;
  assign cyc_win   = cyc_req & ~ext_req & ~coin_req;
  assign grant     = ext_req | coin_req | cyc_req;

  assign trg_enb_out = run_enb_in & in_idle;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and acknowledge timeout detection
  always_comb begin
    state_nxt = state;
    tmo_exp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (eff_trg_in || trg_busy_in) begin
          state_nxt = ST_WAIT_BUSY;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_exp   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (!trg_busy_in && !eff_trg_in) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clocks spent waiting for the acknowledge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tmo_cnt <= '0;
    end else if (state != ST_WAIT_ACK) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Coincidence level delay for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      coin_d <= 1'b0;
    end else begin
      coin_d <= coincid_trg_in;
    end
  end

  // Prescale counter: advances only on masked edges seen while requests are evaluated
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pre_cnt <= '0;
    end else if (cnt_clr_in) begin
      pre_cnt <= '0;
    end else if (req_ok && coin_m) begin
      pre_cnt <= pre_hit ? '0 : pre_cnt + 1'b1;
    end
  end

  // Cycled pending flag; a fresh tick re-arms it even when the old one is granted
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cyc_pend <= 1'b0;
    end else if (!run_enb_in) begin
      cyc_pend <= 1'b0;
    end else if (cyc_tick) begin
      cyc_pend <= 1'b1;
    end else if (cyc_win) begin
      cyc_pend <= 1'b0;
    end
  end

  // Grant pulses and source code of the last grant
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ext_trg_out     <= 1'b0;
      coincid_trg_out <= 1'b0;
      cycled_trg_out  <= 1'b0;
      trg_src_out     <= SRC_NONE;
    end else begin
      ext_trg_out     <= ext_req;
      coincid_trg_out <= coin_win;
      cycled_trg_out  <= cyc_win;
      if (ext_req) begin
        trg_src_out <= SRC_EXT;
      end else if (coin_win) begin
        trg_src_out <= SRC_COIN;
      end else if (cyc_win) begin
        trg_src_out <= SRC_CYC;
      end
    end
  end

  // Trigger ID and per-source accepted counters (wrapping, clear has priority)
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      trg_id_out      <= '0;
      ext_cnt_out     <= '0;
      coincid_cnt_out <= '0;
      cyc_cnt_out     <= '0;
    end else if (cnt_clr_in) begin
      trg_id_out      <= '0;
      ext_cnt_out     <= '0;
      coincid_cnt_out <= '0;
      cyc_cnt_out     <= '0;
    end else begin
      if (eff_trg_in) trg_id_out      <= trg_id_out + 1'b1;
      if (ext_req)    ext_cnt_out     <= ext_cnt_out + 1'b1;
      if (coin_win)   coincid_cnt_out <= coincid_cnt_out + 1'b1;
      if (cyc_win)    cyc_cnt_out     <= cyc_cnt_out + 1'b1;
    end
  end

  // Lost events of this clock; several can coincide
  always_comb begin
    lost_inc = 3'd0;
    if (ext_req && coin_req)              lost_inc = lost_inc + 3'd1;
    if (!in_idle && ext_m)                lost_inc = lost_inc + 3'd1;
    if (!in_idle && coin_m)               lost_inc = lost_inc + 3'd1;
    if (cyc_tick && cyc_pend && !cyc_win) lost_inc = lost_inc + 3'd1;
    if (tmo_exp)                          lost_inc = lost_inc + 3'd1;
  end

  assign lost_sum = {1'b0, lost_trg_cnt_out} + LOST_W'(lost_inc);

  // Lost-trigger counter, saturating at all-ones
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lost_trg_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      lost_trg_cnt_out <= '0;
    end else if (lost_sum[CNT_W]) begin
      lost_trg_cnt_out <= '1;
    end else begin
      lost_trg_cnt_out <= lost_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_trg_src_sched.sv
// Directed bench for trg_src_sched: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-derived per scenario.
`timescale 1ns/1ps
module tb_trg_src_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        run_enb_in;
  logic [2:0]  src_mask_in;
  logic        coincid_trg_in;
  logic        ext_trg_syn_in;
  logic [15:0] cyc_period_in;
  logic [7:0]  coincid_prescale_in;
  logic        eff_trg_in;
  logic        trg_busy_in;
  logic        cnt_clr_in;
  logic        coincid_trg_out;
  logic        ext_trg_out;
  logic        cycled_trg_out;
  logic        trg_enb_out;
  logic [1:0]  trg_src_out;
  logic [15:0] trg_id_out;
  logic [15:0] coincid_cnt_out;
  logic [15:0] ext_cnt_out;
  logic [15:0] cyc_cnt_out;
  logic [15:0] lost_trg_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  trg_src_sched dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .run_enb_in          (run_enb_in),
    .src_mask_in         (src_mask_in),
    .coincid_trg_in      (coincid_trg_in),
    .ext_trg_syn_in      (ext_trg_syn_in),
    .cyc_period_in       (cyc_period_in),
    .coincid_prescale_in (coincid_prescale_in),
    .eff_trg_in          (eff_trg_in),
    .trg_busy_in         (trg_busy_in),
    .cnt_clr_in          (cnt_clr_in),
    .coincid_trg_out     (coincid_trg_out),
    .ext_trg_out         (ext_trg_out),
    .cycled_trg_out      (cycled_trg_out),
    .trg_enb_out         (trg_enb_out),
    .trg_src_out         (trg_src_out),
    .trg_id_out          (trg_id_out),
    .coincid_cnt_out     (coincid_cnt_out),
    .ext_cnt_out         (ext_cnt_out),
    .cyc_cnt_out         (cyc_cnt_out),
    .lost_trg_cnt_out    (lost_trg_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clr_cnt();
    cnt_clr_in = 1'b1;
    cyc(1);
    cnt_clr_in = 1'b0;
  endtask

  // Acknowledge a grant: one eff pulse, then one idle clock back to IDLE
  task automatic ack_eff();
    eff_trg_in = 1'b1;
    cyc(1);
    eff_trg_in = 1'b0;
    cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    int   grants;

    rst_in              = 1'b0;
    run_enb_in          = 1'b0;
    src_mask_in         = 3'b111;
    coincid_trg_in      = 1'b0;
    ext_trg_syn_in      = 1'b0;
    cyc_period_in       = 16'd0;
    coincid_prescale_in = 8'd0;
    eff_trg_in          = 1'b0;
    trg_busy_in         = 1'b0;
    cnt_clr_in          = 1'b0;

    // Reset state
    cyc(3);
    check("rst_coin_out", coincid_trg_out, 0);
    check("rst_ext_out", ext_trg_out, 0);
    check("rst_cyc_out", cycled_trg_out, 0);
    check("rst_enb", trg_enb_out, 0);
    check("rst_src", trg_src_out, 0);
    check("rst_id", trg_id_out, 0);
    check("rst_lost", lost_trg_cnt_out, 0);
    rst_in = 1'b1;
    run_enb_in = 1'b1;
    cyc(9);
    check("idle_enb", trg_enb_out, 1);

    // Single coincidence edge, prescale 0
    coincid_trg_in = 1'b1;
    cyc(1);
    check("t1_coin_pulse", coincid_trg_out, 1);
    check("t1_src", trg_src_out, 1);
    check("t1_enb_low", trg_enb_out, 0);
    check("t1_coin_cnt", coincid_cnt_out, 1);
    eff_trg_in = 1'b1;
    cyc(1);
    eff_trg_in = 1'b0;
    check("t1_pulse_1clk", coincid_trg_out, 0);
    check("t1_id", trg_id_out, 1);
    cyc(1);
    check("t1_back_idle", trg_enb_out, 1);
    coincid_trg_in = 1'b0;
    cyc(3);

    // Prescale 3: only the 4th and 8th edges are granted
    clr_cnt();
    coincid_prescale_in = 8'd3;
    cyc(2);
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      coincid_trg_in = 1'b1;
      cyc(1);
      check($sformatf("t2_edge%0d", i), coincid_trg_out, ((i % 4) == 3) ? 1 : 0);
      coincid_trg_in = 1'b0;
      if (coincid_trg_out) begin
        grants++;
        ack_eff();
        cyc(37);
      end else begin
        cyc(39);
      end
    end
    check("t2_coin_cnt", coincid_cnt_out, 2);
    check("t2_lost", lost_trg_cnt_out, 0);
    coincid_prescale_in = 8'd0;

    // External and coincidence in the same IDLE cycle
    clr_cnt();
    cyc(2);
    ext_trg_syn_in = 1'b1;
    coincid_trg_in = 1'b1;
    cyc(1);
    ext_trg_syn_in = 1'b0;
    coincid_trg_in = 1'b0;
    check("t3_ext_pulse", ext_trg_out, 1);
    check("t3_no_coin", coincid_trg_out, 0);
    check("t3_src", trg_src_out, 2);
    check("t3_lost", lost_trg_cnt_out, 1);
    check("t3_ext_cnt", ext_cnt_out, 1);
    check("t3_coin_cnt", coincid_cnt_out, 0);
    ack_eff();

    // Cycled period 100 with busy held 250 clocks after the first grant
    clr_cnt();
    cyc_period_in = 16'd100;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      cyc(1);
      if (cycled_trg_out) seen = 1'b1;
    end
    check("t4_first_grant", seen, 1);
    check("t4_cyc_cnt1", cyc_cnt_out, 1);
    check("t4_src", trg_src_out, 3);
    trg_busy_in = 1'b1;
    cyc(250);
    check("t4_lost_busy", lost_trg_cnt_out, 1);
    trg_busy_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      if (cycled_trg_out) seen = 1'b1;
    end
    check("t4_second_grant", seen, 1);
    check("t4_cyc_cnt2", cyc_cnt_out, 2);
    check("t4_lost_final", lost_trg_cnt_out, 1);
    cyc_period_in = 16'd0;
    ack_eff();

    // Grant never acknowledged: timeout after 8 clocks
    clr_cnt();
    cyc(2);
    ext_trg_syn_in = 1'b1;
    cyc(1);
    ext_trg_syn_in = 1'b0;
    check("t5_ext_pulse", ext_trg_out, 1);
    cyc(7);
    check("t5_still_wait", trg_enb_out, 0);
    check("t5_lost_before", lost_trg_cnt_out, 0);
    cyc(1);
    check("t5_timeout_idle", trg_enb_out, 1);
    check("t5_lost", lost_trg_cnt_out, 1);
    check("t5_id", trg_id_out, 0);

    // Run disabled: no grants
    run_enb_in = 1'b0;
    ext_trg_syn_in = 1'b1;
    cyc(1);
    ext_trg_syn_in = 1'b0;
    check("t6_no_grant", ext_trg_out, 0);
    check("t6_enb_off", trg_enb_out, 0);

    // Trigger ID wrap, then clear together with eff
    eff_trg_in = 1'b1;
    cyc(65535);
    eff_trg_in = 1'b0;
    check("t6_id_max", trg_id_out, 16'hFFFF);
    eff_trg_in = 1'b1;
    cyc(1);
    eff_trg_in = 1'b0;
    check("t6_id_wrap", trg_id_out, 0);
    check("t6_ext_cnt_pre", ext_cnt_out, 1);
    check("t6_lost_pre", lost_trg_cnt_out, 1);
    eff_trg_in = 1'b1;
    cnt_clr_in = 1'b1;
    cyc(1);
    eff_trg_in = 1'b0;
    cnt_clr_in = 1'b0;
    check("t6_clr_id", trg_id_out, 0);
    check("t6_clr_ext", ext_cnt_out, 0);
    check("t6_clr_lost", lost_trg_cnt_out, 0);

    // Asynchronous reset while a grant pulse is high
    run_enb_in = 1'b1;
    cyc(1);
    ext_trg_syn_in = 1'b1;
    cyc(1);
    ext_trg_syn_in = 1'b0;
    check("t7_ext_pulse", ext_trg_out, 1);
    #2;
    rst_in = 1'b0;
    #1;
    check("t7_rst_pulse", ext_trg_out, 0);
    check("t7_rst_src", trg_src_out, 0);
    check("t7_rst_cnt", ext_cnt_out, 0);
    cyc(2);
    rst_in = 1'b1;
    cyc(3);
    check("t7_no_pulse_after", ext_trg_out, 0);
    check("t7_idle_after", trg_enb_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
